uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Byte-wide transmit buffer directly upstream of the uart block.
- Accepts bytes from the host side with a valid/ready handshake and stores them in a circular FIFO.
- Launches stored bytes one at a time into the uart transmitter's din/wr_en inputs, pacing on tx_busy.
- Lets software burst several bytes without polling tx_busy per byte.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 4: pointer width; must equal log2(DEPTH).
- BUSY_TIMEOUT, 8: cycles to wait for tx_busy to rise after a launch before the byte is treated as accepted.

Ports:
- clk_50m  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_data  input  8  byte to enqueue.
- wr_valid  input  1  enqueue request.
- wr_ready  output  1  high when not full.
- flush  input  1  synchronous clear of queued contents.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  bytes currently stored; excludes the byte in flight.
- overflow  output  1  sticky: a push was attempted while full.
- uart_din  output  8  byte to the transmitter; registered and held stable.
- uart_wr_en  output  1  one-cycle launch strobe to the transmitter.
- uart_tx_busy  input  1  transmitter busy flag.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, count and overflow go to 0; FSM goes to IDLE.
  - Outputs: uart_din=0x00, uart_wr_en=0, empty=1, full=0, wr_ready=1.
  - Storage contents are don't-care.
  - Reset mid-transfer abandons the in-flight byte and all queued bytes.
- Push:
  - A push occurs on an edge where wr_valid=1 and full=0.
  - wr_data is written at the write pointer, the pointer increments mod DEPTH, and count increments.
  - A push attempt while full drops the byte, sets overflow, and leaves count unchanged.
  - Push acceptance uses the pre-edge full value; a same-cycle pop does not free space for that push.
- FSM has three states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Exits when empty=0 and uart_tx_busy=0.
  - On exit: head byte is registered into uart_din, read pointer increments, count decrements, uart_wr_en=1 for exactly one cycle, and the next state is WAIT_BUSY.
  - Pop uses the pre-edge empty value, so a byte pushed into an empty FIFO launches at the earliest on the following edge.
  - With an idle transmitter, uart_wr_en goes high in the cycle after the cycle in which count went 0->1.
- WAIT_BUSY:
  - Goes to WAIT_DONE when uart_tx_busy=1.
  - A timeout counter starts at 0; on reaching BUSY_TIMEOUT without seeing busy, the state returns to IDLE.
  - uart_wr_en is not re-asserted; the byte is not retried.
- WAIT_DONE: returns to IDLE when uart_tx_busy=0.
- uart_din holds its value until the next launch; it does not change outside launch edges.
- Simultaneous push and pop when not full: both take effect, count unchanged, pointers both advance.
- Pointer wrap-around: pointers wrap from DEPTH-1 to 0; full/empty are derived from count, not pointer equality.
- flush=1:
  - Pointers and count go to 0 and overflow clears on that edge.
  - A concurrent push is discarded and does not set overflow.
  - A concurrent pop is suppressed.
  - The FSM state, uart_din and the in-flight byte are unaffected; the current transfer completes.
- Derived outputs:
  - wr_ready = ~full.
  - full and empty are combinational from count.
  - Count arithmetic is unsigned ADDR_W+1 bits, never exceeding DEPTH.

Test Plan:
- Reset then single byte:
  - Stimulus: release rst; push 0xA5 with uart_tx_busy=0; model busy high 1 cycle after the strobe for 20 cycles.
  - Response: uart_wr_en pulses once, one cycle after the push, with uart_din=0xA5; count returns to 0; empty=1.
- Burst to full:
  - Stimulus: hold uart_tx_busy=1; push 17 bytes 0x00..0x10 (DEPTH=16).
  - Response: full=1 after the 16th push, wr_ready=0, overflow=1, count=16.
  - Then release busy: bytes 0x00..0x0F emerge in order, one per transmitter frame; 0x10 is never sent.
- Wrap-around:
  - Stimulus: push/pop interleaved with 40 bytes total, count peaking at 5.
  - Response: output order matches input order across pointer wrap; count is never negative and final count is 0.
- Timeout:
  - Stimulus: push 0x3C with uart_tx_busy tied 0.
  - Response: single uart_wr_en pulse; FSM back in IDLE after BUSY_TIMEOUT=8 cycles; no second pulse for 0x3C.
- Flush during transfer:
  - Stimulus: queue 0x11,0x22,0x33; assert flush for 1 cycle while 0x11 is in WAIT_DONE, with a concurrent push of 0x44.
  - Response: count=0, overflow=0, 0x11 completes, and 0x22/0x33/0x44 are never launched.
- Async reset mid-frame:
  - Stimulus: pull rst low between clock edges while in WAIT_DONE with 3 bytes queued.
  - Response: outputs reach their reset values immediately, before the next edge; after rst high no uart_wr_en occurs until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: buffers host writes and launches
// one byte at a time into the transmitter, pacing on its busy flag.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        uart_din,
    output logic              uart_wr_en,
    input  logic              uart_tx_busy
);

    localparam int                TMO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_d;
    logic              push;
    logic              pop;

    // Full/empty come from the occupancy count so pointer equality never has to be disambiguated.
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign wr_ready = ~full;

    assign push = wr_valid & ~full & ~flush;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !uart_tx_busy && !flush) begin
                    pop     = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A transmitter that never raises busy is assumed to have taken the byte.
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            uart_din   <= '0;
            uart_wr_en <= 1'b0;
        end else begin
            uart_wr_en <= pop;
            if (pop) begin
                uart_din <= mem[rd_ptr_q];
            end
            // Flush empties the queue only; a byte already launched is left to finish.
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                count <= count_d;
                if (wr_valid && full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule
